// File: rtl/ro_trng_core.sv
// Ring-oscillator TRNG core: Johnson-ring channels XOR-combined, prescaled sampling,
// optional von Neumann debiasing, word packing with valid/ready output and a repetition health test.
module ro_trng_core #(
    parameter int N_RO      = 10,
    parameter int STAGES    = 9,
    parameter int WORD_W    = 8,
    parameter int DIV_W     = 8,
    parameter int REP_LIMIT = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [DIV_W-1:0]  SAMPLE_DIV,
    input  logic              DEBIAS_EN,
    input  logic              RND_READY,
    output logic [WORD_W-1:0] RND_DATA,
    output logic              RND_VALID,
    output logic              RAW_BIT,
    output logic              HEALTH_FAIL,
    output logic              OVERRUN
);

    localparam int RUN_W = $clog2(REP_LIMIT + 1);
    localparam int CNT_W = $clog2(WORD_W + 1);

    localparam logic [DIV_W-1:0] DIV_ONE  = 1;
    localparam logic [RUN_W-1:0] RUN_ONE  = 1;
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(REP_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    logic [N_RO-1:0] ro_out;
    logic            raw;

    for (genvar gi = 0; gi < N_RO; gi++) begin : g_ro
        localparam int L = STAGES + 2 * gi;
        logic [L-1:0] ring;

        always_ff @(posedge CLK) begin
            if (RST)
                ring <= '0;
            else if (EN)
                ring <= {ring[L-2:0], ~ring[L-1]};
        end

        assign ro_out[gi] = ring[L-1];
    end

    assign raw = ^ro_out;

    // Down-counting prescaler; SAMPLE_DIV is only reloaded at terminal count.
    logic [DIV_W-1:0] div_cnt;
    logic             samp;

    assign samp = EN && (div_cnt == '0);

    always_ff @(posedge CLK) begin
        if (RST)
            div_cnt <= '0;
        else if (EN)
            div_cnt <= (div_cnt == '0) ? SAMPLE_DIV : div_cnt - DIV_ONE;
    end

    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_nxt;

    always_comb begin
        run_nxt = run_cnt;
        if (samp) begin
            if (run_cnt != '0 && raw == RAW_BIT)
                run_nxt = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_ONE;
            else
                run_nxt = RUN_ONE;
        end
    end

    // A change of DEBIAS_EN since last cycle invalidates any half-collected pair.
    logic deb_q;
    logic slot_full;
    logic slot_bit;
    logic slot_live;
    logic emit;
    logic emit_bit;

    assign slot_live = slot_full && (deb_q == DEBIAS_EN);

    always_comb begin
        emit     = 1'b0;
        emit_bit = raw;
        if (samp) begin
            if (!DEBIAS_EN) begin
                emit = 1'b1;
            end else if (slot_live && slot_bit != raw) begin
                emit     = 1'b1;
                emit_bit = slot_bit;
            end
        end
    end

    logic [WORD_W-1:0] sh;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] word_nxt;
    logic              word_done;
    logic              out_free;
    logic              load;

    assign word_nxt  = {sh[WORD_W-2:0], emit_bit};
    assign word_done = emit && (bit_cnt == LAST_BIT);
    assign out_free  = !RND_VALID || RND_READY;
    assign load      = word_done && !HEALTH_FAIL && out_free;

    always_ff @(posedge CLK) begin
        if (RST) begin
            RAW_BIT     <= 1'b0;
            run_cnt     <= '0;
            HEALTH_FAIL <= 1'b0;
            deb_q       <= 1'b0;
            slot_full   <= 1'b0;
            slot_bit    <= 1'b0;
            sh          <= '0;
            bit_cnt     <= '0;
            RND_DATA    <= '0;
            RND_VALID   <= 1'b0;
            OVERRUN     <= 1'b0;
        end else begin
            deb_q   <= DEBIAS_EN;
            run_cnt <= run_nxt;
            if (samp)
                RAW_BIT <= raw;
            if (run_nxt == RUN_MAX)
                HEALTH_FAIL <= 1'b1;

            if (samp && DEBIAS_EN) begin
                if (slot_live) begin
                    slot_full <= 1'b0;
                end else begin
                    slot_full <= 1'b1;
                    slot_bit  <= raw;
                end
            end else if (deb_q != DEBIAS_EN) begin
                slot_full <= 1'b0;
            end

            if (emit) begin
                sh      <= word_nxt;
                bit_cnt <= word_done ? '0 : bit_cnt + CNT_ONE;
            end

            if (word_done && !HEALTH_FAIL && !out_free)
                OVERRUN <= 1'b1;

            if (HEALTH_FAIL) begin
                RND_VALID <= 1'b0;
            end else if (load) begin
                RND_DATA  <= word_nxt;
                RND_VALID <= 1'b1;
            end else if (RND_VALID && RND_READY) begin
                RND_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ro_trng_core.sv
// Directed bench for ro_trng_core: three instances (single short ring, fast-failing health
// config, default parameters) driven by shared stimulus with hand-computed expectations.
module tb_ro_trng_core;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic [7:0] SAMPLE_DIV;
    logic       DEBIAS_EN;
    logic       RND_READY;

    logic [7:0] a_data, b_data, c_data;
    logic       a_valid, b_valid, c_valid;
    logic       a_raw, b_raw, c_raw;
    logic       a_hf, b_hf, c_hf;
    logic       a_ovr, b_ovr, c_ovr;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ro_trng_core #(.N_RO(1), .STAGES(3), .WORD_W(8), .DIV_W(8), .REP_LIMIT(32)) dut_a (
        .CLK(CLK), .RST(RST), .EN(EN), .SAMPLE_DIV(SAMPLE_DIV), .DEBIAS_EN(DEBIAS_EN),
        .RND_READY(RND_READY), .RND_DATA(a_data), .RND_VALID(a_valid), .RAW_BIT(a_raw),
        .HEALTH_FAIL(a_hf), .OVERRUN(a_ovr)
    );

    ro_trng_core #(.N_RO(1), .STAGES(5), .WORD_W(8), .DIV_W(8), .REP_LIMIT(4)) dut_b (
        .CLK(CLK), .RST(RST), .EN(EN), .SAMPLE_DIV(SAMPLE_DIV), .DEBIAS_EN(DEBIAS_EN),
        .RND_READY(RND_READY), .RND_DATA(b_data), .RND_VALID(b_valid), .RAW_BIT(b_raw),
        .HEALTH_FAIL(b_hf), .OVERRUN(b_ovr)
    );

    ro_trng_core dut_c (
        .CLK(CLK), .RST(RST), .EN(EN), .SAMPLE_DIV(SAMPLE_DIV), .DEBIAS_EN(DEBIAS_EN),
        .RND_READY(RND_READY), .RND_DATA(c_data), .RND_VALID(c_valid), .RAW_BIT(c_raw),
        .HEALTH_FAIL(c_hf), .OVERRUN(c_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    logic [7:0] raw_seq;

    initial begin
        // Reset with enable high and garbage inputs
        RST        = 1'b1;
        EN         = 1'b1;
        SAMPLE_DIV = 8'hA5;
        DEBIAS_EN  = 1'b1;
        RND_READY  = 1'b1;
        tick(2);
        chk("rst_a_data",  32'(a_data),  32'h0);
        chk("rst_a_valid", 32'(a_valid), 32'h0);
        chk("rst_a_raw",   32'(a_raw),   32'h0);
        chk("rst_a_hf",    32'(a_hf),    32'h0);
        chk("rst_a_ovr",   32'(a_ovr),   32'h0);
        chk("rst_b_hf",    32'(b_hf),    32'h0);
        chk("rst_c_valid", 32'(c_valid), 32'h0);
        chk("rst_c_data",  32'(c_data),  32'h0);

        // Plain path, STAGES=3: raw 0,0,0,1,1,1,0,0 -> word 0x1C on 8th sample
        SAMPLE_DIV = 8'd0;
        DEBIAS_EN  = 1'b0;
        RST        = 1'b0;
        raw_seq    = 8'b0001_1100;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("plain_raw", 32'(a_raw), 32'(raw_seq[7-i]));
            if (i < 7)
                chk("plain_valid_early", 32'(a_valid), 32'h0);
        end
        chk("plain_valid", 32'(a_valid), 32'h1);
        chk("plain_data",  32'(a_data),  32'h1C);
        tick(1);
        chk("plain_valid_drop", 32'(a_valid), 32'h0);

        // Debiased: zero bits emitted at samples 4,10,..,46
        RST = 1'b1;
        tick(1);
        RST       = 1'b0;
        DEBIAS_EN = 1'b1;
        tick(45);
        chk("deb_valid_early", 32'(a_valid), 32'h0);
        tick(1);
        chk("deb_valid", 32'(a_valid), 32'h1);
        chk("deb_data",  32'(a_data),  32'h00);
        tick(2);
        chk("deb_hf", 32'(a_hf), 32'h0);

        // Backpressure: 0x1C held, 0x71 dropped, 0xC7 loads after one accept
        RST       = 1'b1;
        DEBIAS_EN = 1'b0;
        RND_READY = 1'b0;
        tick(1);
        RST = 1'b0;
        tick(8);
        chk("bp_valid1", 32'(a_valid), 32'h1);
        chk("bp_data1",  32'(a_data),  32'h1C);
        tick(7);
        chk("bp_ovr_early", 32'(a_ovr),  32'h0);
        chk("bp_hold_data", 32'(a_data), 32'h1C);
        tick(1);
        chk("bp_ovr",       32'(a_ovr),   32'h1);
        chk("bp_hold_valid",32'(a_valid), 32'h1);
        chk("bp_kept_data", 32'(a_data),  32'h1C);
        RND_READY = 1'b1;
        tick(1);
        chk("bp_accept_valid", 32'(a_valid), 32'h0);
        chk("bp_accept_data",  32'(a_data),  32'h1C);
        RND_READY = 1'b0;
        tick(6);
        chk("bp_idle_valid", 32'(a_valid), 32'h0);
        chk("bp_idle_data",  32'(a_data),  32'h1C);
        tick(1);
        chk("bp_valid3", 32'(a_valid), 32'h1);
        chk("bp_data3",  32'(a_data),  32'hC7);

        // Health test on dut_b: REP_LIMIT=4, STAGES=5 -> five zeros in a row
        RST       = 1'b1;
        RND_READY = 1'b1;
        tick(1);
        RST = 1'b0;
        tick(3);
        chk("hf_early", 32'(b_hf), 32'h0);
        tick(1);
        chk("hf_set", 32'(b_hf), 32'h1);
        tick(2);
        chk("hf_raw_alive", 32'(b_raw), 32'h1);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("hf_valid_blocked", 32'(b_valid), 32'h0);
        end
        chk("hf_sticky", 32'(b_hf), 32'h1);
        RST = 1'b1;
        tick(1);
        chk("hf_cleared", 32'(b_hf), 32'h0);

        // Prescaler SAMPLE_DIV=3 with EN gaps: samples at enabled cycles 1,5,9,..,29
        SAMPLE_DIV = 8'd3;
        tick(1);
        RST = 1'b0;
        tick(1);
        chk("div_raw_ec1", 32'(a_raw), 32'h0);
        tick(4);
        chk("div_raw_ec5", 32'(a_raw), 32'h1);
        EN = 1'b0;
        tick(3);
        chk("div_raw_hold", 32'(a_raw), 32'h1);
        EN = 1'b1;
        tick(2);
        chk("div_raw_ec7", 32'(a_raw), 32'h1);
        tick(2);
        chk("div_raw_ec9", 32'(a_raw), 32'h0);
        EN = 1'b0;
        tick(5);
        EN = 1'b1;
        tick(8);
        chk("div_raw_ec17", 32'(a_raw), 32'h1);
        tick(11);
        chk("div_valid_ec28", 32'(a_valid), 32'h0);
        tick(1);
        chk("div_valid_ec29", 32'(a_valid), 32'h1);
        chk("div_data",       32'(a_data),  32'h49);

        // Default parameters, 10k samples: no health failure
        RST        = 1'b1;
        SAMPLE_DIV = 8'd0;
        tick(1);
        RST = 1'b0;
        tick(10000);
        chk("default_hf", 32'(c_hf), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
